sseg_mux_driver: RTL
====================

SSEG_MUX_DRIVER -- requirements
Module: sseg_mux_driver

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NDIG, 4: digit count, legal range 1..8.
- REFRESH_DIV, 50000: clock cycles per digit slot, minimum 2.
- BLANK_CYC, 16: anti-ghost blank cycles at the start of each slot; must be less than REFRESH_DIV.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the single clock; all logic on its rising edge.
- rst, in, 1: reset, synchronous, active-high.
- Value, in, 4*NDIG: hex nibbles; nibble i drives digit i; digit NDIG-1 is most significant.
- Load, in, 1: capture Value into the pending register on this clk edge.
- SSeg, out, 7: segments {a,b,c,d,e,f,g}, bit6=a, bit0=g; active-low.
- An, out, NDIG: digit enables, active-low.
- FrameTick, out, 1: one-cycle pulse when a frame completes.

Function
REQ-003 Hex decode SHALL be, for 0..F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
REQ-004 Slot counter cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; digit index idx SHALL increment when cnt==REFRESH_DIV-1 and wrap from NDIG-1 to 0.
REQ-005 All outputs SHALL be registered, reflecting cnt/idx one cycle late.
REQ-006 When cnt<BLANK_CYC, An SHALL be all ones and SSeg SHALL be 7'h7F.
REQ-007 Otherwise An SHALL have only bit idx low, and SSeg SHALL be the decode of committed nibble idx.
REQ-008 Load SHALL write the pending register; a later Load before commit SHALL overwrite it.
REQ-009 Pending SHALL copy to committed only on the cycle where cnt==REFRESH_DIV-1 and idx==NDIG-1, so no frame mixes two values (no tearing).
REQ-010 FrameTick SHALL be high for exactly the registered cycle following that commit cycle.
REQ-011 A Load on the commit cycle SHALL itself be committed, with Value passed through to the committed register.
REQ-012 With NDIG=1, idx SHALL stay 0, and FrameTick SHALL pulse once every REFRESH_DIV cycles.

Reset
REQ-013 While rst is high at a clk edge: cnt=0, idx=0, pending=0, committed=0, SSeg=7'h7F, An all ones, FrameTick=0.
REQ-014 Reset mid-frame SHALL abort the frame; the first slot after release SHALL be digit 0 starting at cnt=0.

Configuration
REQ-015 Macro SSEG_LZ_SUPPRESS_EN, when defined, SHALL force SSeg=7'h7F in digit i's active window if nibble i and all more significant nibbles are zero, for i>0.
REQ-016 Under SSEG_LZ_SUPPRESS_EN, digit 0 SHALL always be shown, and An timing SHALL be unchanged.
REQ-017 Without SSEG_LZ_SUPPRESS_EN, every digit SHALL show its decoded nibble, including leading zeros.

Structure
REQ-018 Package sseg_pkg SHALL hold the 16-entry decode table and the SSEG_BLANK=7'h7F constant.
REQ-019 Sub-module sseg_hex_decode SHALL be a combinational 4-bit to 7-bit lookup from sseg_pkg; everything else SHALL live in sseg_mux_driver.

Verification
All scenarios use NDIG=4, REFRESH_DIV=8, BLANK_CYC=2.
REQ-020 Reset: rst high for 3 cycles -> SSeg=7F, An=F, FrameTick=0 on each.
REQ-021 Load 16'h12AF, run two frames -> second frame digits 0..3 show 0111000, 0001000, 0010010, 1001111, with An=E,D,B,7.
REQ-022 Blanking: each 8-cycle slot -> An=F and SSeg=7F for exactly 2 cycles, then active for 6.
REQ-023 Tearing and overwrite: Load 16'h1111, then 16'h2222, mid-frame -> frame in progress unchanged; next frame shows 2222; FrameTick pulses once per 32 cycles.
REQ-024 LZ with macro: Load 16'h0040 -> digits 3 and 2 SSeg=7F, digit 1 =1001100, digit 0 =0000001; Load 0 -> only digit 0 lit.
REQ-025 LZ without macro: Load 16'h0040 -> all four digits show their values. Reset mid-frame at cnt=5, idx=2 -> REQ-013 values, then restart at digit 0.

Source files
------------

// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_pkg
//  Description : Shared types and constants for the seven-segment display
//                driver. It holds the 16-entry hex-to-segment table and the
//                all-segments-off pattern.
//                Segment order is {a,b,c,d,e,f,g}: bit6 = a, bit0 = g.
//                The segments are active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
package sseg_pkg;

    typedef logic [6:0] seg_t;

    // Pattern that drives every segment off (active-low).
    localparam seg_t SSEG_BLANK = 7'h7F;

    // Entry N is the segment pattern for hex digit N. The list below runs
    // from F (left) down to 0 (right), so each index lines up with its digit.
    localparam logic [15:0][6:0] SSEG_HEX_TABLE = {
        7'b0111000,     // F
        7'b0110000,     // E
        7'b1000010,     // D
        7'b0110001,     // C
        7'b1100000,     // B
        7'b0001000,     // A
        7'b0000100,     // 9
        7'b0000000,     // 8
        7'b0001111,     // 7
        7'b0100000,     // 6
        7'b0100100,     // 5
        7'b1001100,     // 4
        7'b0000110,     // 3
        7'b0010010,     // 2
        7'b1001111,     // 1
        7'b0000001      // 0
    };

    function automatic seg_t sseg_lookup(input logic [3:0] nib);
        return SSEG_HEX_TABLE[nib];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_hex_decode
//  Description : Combinational lookup from a 4-bit hex nibble to its 7-bit
//                active-low segment pattern. The pattern comes from sseg_pkg.
//  Ports       : nibble_i [3:0] - hex digit to decode
//                seg_o    [6:0] - {a,b,c,d,e,f,g}, active-low
//  Revision    : 1.0 - initial release
// ============================================================================
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    assign seg_o = sseg_lookup(nibble_i);

endmodule
`default_nettype wire

// File: rtl/sseg_mux_driver.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_mux_driver
//  Description : Time-multiplexed driver for an NDIG-digit common-anode hex
//                display.
//                - Each digit owns a slot of REFRESH_DIV clocks.
//                - The first BLANK_CYC clocks of each slot are dark, which
//                  suppresses ghosting.
//                - New values are staged in a pending register.
//                - The pending value is copied to the displayed (committed)
//                  register only at the last clock of a frame. A frame
//                  therefore never shows a mix of two values.
//                Every output is registered, so the outputs follow the
//                slot counter by one clock.
//  Parameters  : NDIG        - digit count, 1..8
//                REFRESH_DIV - clocks per digit slot, >= 2
//                BLANK_CYC   - dark clocks at the start of a slot, < REFRESH_DIV
//  Ports       : clk       - rising-edge clock
//                rst       - synchronous active-high reset
//                Value     - 4*NDIG hex nibbles; nibble i drives digit i
//                Load      - capture Value into the pending register
//                SSeg      - segments {a..g}, active-low
//                An        - digit enables, active-low
//                FrameTick - one-clock pulse after each frame commit
//  Options     : SSEG_LZ_SUPPRESS_EN - when defined, leading-zero digits
//                (i > 0) are blanked. Digit 0 is always shown.
//  Revision    : 1.0 - initial release
// ============================================================================
module sseg_mux_driver
    import sseg_pkg::*;
#(
    parameter int NDIG        = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] Value,
    input  logic              Load,
    output logic [6:0]        SSeg,
    output logic [NDIG-1:0]   An,
    output logic              FrameTick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIG - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic [IDX_W-1:0]  idx_q,  idx_d;
    logic [4*NDIG-1:0] pend_q, pend_d;
    logic [4*NDIG-1:0] comm_q, comm_d;
    seg_t              sseg_q, sseg_d;
    logic [NDIG-1:0]   an_q,   an_d;
    logic              tick_q, tick_d;

    logic              w_slot_end;
    logic              w_commit;
    logic [3:0]        w_nib;
    seg_t              w_seg;
    logic              w_lz_blank;

    assign w_slot_end = (cnt_q == CNT_LAST);
    assign w_commit   = w_slot_end && (idx_q == IDX_LAST);

`ifdef SSEG_LZ_SUPPRESS_EN
    // w_lz_dig[i] is set when digit i and every more significant digit are
    // zero. Digit 0 is never blanked, so a zero value still shows "0".
    logic [NDIG-1:0] w_lz_dig;

    assign w_lz_dig[0] = 1'b0;

    for (genvar gi = 1; gi < NDIG; gi++) begin : g_lz_dig
        assign w_lz_dig[gi] = (comm_q[4*NDIG-1:4*gi] == '0);
    end
`endif

    // Select the committed nibble, and its leading-zero flag, for the
    // current slot. The comparison loop is used instead of an indexed part
    // select because idx_q can hold codes >= NDIG when NDIG is not a power
    // of two.
    always_comb begin
        w_nib      = 4'h0;
        w_lz_blank = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IDX_W'(i)) begin
                w_nib = comm_q[4*i +: 4];
`ifdef SSEG_LZ_SUPPRESS_EN
                w_lz_blank = w_lz_dig[i];
`endif
            end
        end
    end

    sseg_hex_decode u_dec (
        .nibble_i (w_nib),
        .seg_o    (w_seg)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d  = w_slot_end ? '0 : cnt_q + 1'b1;
        idx_d  = idx_q;
        pend_d = pend_q;
        comm_d = comm_q;
        tick_d = w_commit;
        sseg_d = SSEG_BLANK;
        an_d   = '1;

        if (w_slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        if (Load) begin
            pend_d = Value;
        end

        // pend_d already includes a Load that arrives on the commit clock.
        // That value therefore goes straight through to the display.
        if (w_commit) begin
            comm_d = pend_d;
        end

        if (cnt_q >= CNT_BLANK) begin
            an_d   = ~(NDIG'(1) << idx_q);
            sseg_d = w_lz_blank ? SSEG_BLANK : w_seg;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            pend_q <= '0;
            comm_q <= '0;
            sseg_q <= SSEG_BLANK;
            an_q   <= '1;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            pend_q <= pend_d;
            comm_q <= comm_d;
            sseg_q <= sseg_d;
            an_q   <= an_d;
            tick_q <= tick_d;
        end
    end

    assign SSeg      = sseg_q;
    assign An        = an_q;
    assign FrameTick = tick_q;

endmodule
`default_nettype wire
